// File: rtl/risc_pkg.sv
// Shared definitions for the RISC controller: opcodes, phase names and FSM states.
// CTRL_SINGLE_STEP_EN adds the WAIT state used by single-step operation.
package risc_pkg;

    localparam int OPCODE_W = 3;
    localparam int PHASE_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_HLT = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_AND = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_LDA = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_STO = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_JMP = 3'd7;

    localparam logic [PHASE_W-1:0] PH_INST_ADDR  = 3'd0;
    localparam logic [PHASE_W-1:0] PH_INST_FETCH = 3'd1;
    localparam logic [PHASE_W-1:0] PH_INST_LOAD  = 3'd2;
    localparam logic [PHASE_W-1:0] PH_IDLE       = 3'd3;
    localparam logic [PHASE_W-1:0] PH_OP_ADDR    = 3'd4;
    localparam logic [PHASE_W-1:0] PH_OP_FETCH   = 3'd5;
    localparam logic [PHASE_W-1:0] PH_ALU_OP     = 3'd6;
    localparam logic [PHASE_W-1:0] PH_STORE      = 3'd7;

`ifdef CTRL_SINGLE_STEP_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;
`endif

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational control table: (phase, opcode, zero) -> control strobes.
// Run-gating is applied by the caller; this block assumes the core is running.
module risc_ctrl_decode
    import risc_pkg::*;
(
    input  logic [PHASE_W-1:0]  phase,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                ld_ac,
    output logic                wr,
    output logic                data_e,
    output logic                halt
);

    logic aluop;

    assign aluop = is_aluop(opcode);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (phase)
            PH_INST_ADDR: begin
                sel = 1'b1;
            end
            PH_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == OP_HLT);
            end
            PH_OP_FETCH: begin
                rd = aluop;
            end
            PH_ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                inc_pc = (opcode == OP_JMP);
                ld_pc  = (opcode == OP_JMP);
                wr     = (opcode == OP_STO);
                data_e = (opcode == OP_STO);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/risc_controller.sv
// Phase sequencer and control decoder for the simple RISC core.
// Define CTRL_SINGLE_STEP_EN to add step_mode/step inputs and a WAIT state.
module risc_controller
    import risc_pkg::PHASE_W;
#(
    parameter int OPCODE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step_mode,
    input  logic                step,
`endif
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                ld_ac,
    output logic                wr,
    output logic                data_e,
    output logic                halt
);

    import risc_pkg::*;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;

    logic dec_sel, dec_rd, dec_ld_ir, dec_inc_pc, dec_ld_pc;
    logic dec_ld_ac, dec_wr, dec_data_e, dec_halt;

    risc_ctrl_decode u_decode (
        .phase  (phase_q),
        .opcode (opcode),
        .zero   (zero),
        .sel    (dec_sel),
        .rd     (dec_rd),
        .ld_ir  (dec_ld_ir),
        .inc_pc (dec_inc_pc),
        .ld_pc  (dec_ld_pc),
        .ld_ac  (dec_ld_ac),
        .wr     (dec_wr),
        .data_e (dec_data_e),
        .halt   (dec_halt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
                phase_d = '0;
            end
            ST_RUN: begin
                phase_d = phase_q + 3'd1;
                if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
                    state_d = ST_HALTED;
                    phase_d = '0;
                end
`ifdef CTRL_SINGLE_STEP_EN
                else if (phase_q == PH_STORE && step_mode) begin
                    state_d = ST_WAIT;
                    phase_d = '0;
                end
`endif
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
`ifdef CTRL_SINGLE_STEP_EN
            ST_WAIT: begin
                if (step) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Decoded strobes only reach the datapath while running; HALTED shows halt alone.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (state_q == ST_RUN) begin
            sel    = dec_sel;
            rd     = dec_rd;
            ld_ir  = dec_ld_ir;
            inc_pc = dec_inc_pc;
            ld_pc  = dec_ld_pc;
            ld_ac  = dec_ld_ac;
            wr     = dec_wr;
            data_e = dec_data_e;
            halt   = dec_halt;
        end else if (state_q == ST_HALTED) begin
            halt = 1'b1;
        end
    end

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench for risc_controller: directed instruction sequences with hand-computed strobes.
// Exercises the single-step path when CTRL_SINGLE_STEP_EN is defined.
module tb_risc_controller;

    // Output vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    localparam logic [8:0] B_SEL  = 9'b1_0000_0000;
    localparam logic [8:0] B_RD   = 9'b0_1000_0000;
    localparam logic [8:0] B_IR   = 9'b0_0100_0000;
    localparam logic [8:0] B_INC  = 9'b0_0010_0000;
    localparam logic [8:0] B_LDPC = 9'b0_0001_0000;
    localparam logic [8:0] B_LDAC = 9'b0_0000_1000;
    localparam logic [8:0] B_WR   = 9'b0_0000_0100;
    localparam logic [8:0] B_DE   = 9'b0_0000_0010;
    localparam logic [8:0] B_HALT = 9'b0_0000_0001;
    localparam logic [8:0] NONE   = 9'b0;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
`ifdef CTRL_SINGLE_STEP_EN
    logic step_mode = 1'b0;
    logic step = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;
    logic [8:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    risc_controller #(.OPCODE_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
`ifdef CTRL_SINGLE_STEP_EN
        .step_mode (step_mode),
        .step      (step),
`endif
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    // Monitor: one expected vector per cycle, compared mid-cycle.
    initial begin
        logic [8:0] act, e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
                checks++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL %s: got %09b expected %09b", nm, act, e);
                end
            end
        end
    end

    // Drive one cycle's inputs just after the edge and record that cycle's expected strobes.
    task automatic cyc(input logic r, input logic [2:0] op, input logic z,
                       input logic [8:0] e, input string nm);
        @(posedge clk);
        #1;
        rst    = r;
        opcode = op;
        zero   = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic fetch(input logic [2:0] op_f, input string nm);
        cyc(1'b1, op_f, 1'b1, B_SEL,               {nm, "_ph0"});
        cyc(1'b1, op_f, 1'b0, B_SEL | B_RD,        {nm, "_ph1"});
        cyc(1'b1, op_f, 1'b1, B_SEL | B_RD | B_IR, {nm, "_ph2"});
        cyc(1'b1, op_f, 1'b0, B_SEL | B_RD | B_IR, {nm, "_ph3"});
    endtask

    task automatic instr(input logic [2:0] op_f, input logic [2:0] op, input logic z,
                         input logic [8:0] e4, input logic [8:0] e5,
                         input logic [8:0] e6, input logic [8:0] e7, input string nm);
        fetch(op_f, nm);
        cyc(1'b1, op, z, e4, {nm, "_ph4"});
        cyc(1'b1, op, z, e5, {nm, "_ph5"});
        cyc(1'b1, op, z, e6, {nm, "_ph6"});
        cyc(1'b1, op, z, e7, {nm, "_ph7"});
    endtask

    initial begin
        rst = 1'b0; opcode = 3'd0; zero = 1'b0;
        @(posedge clk);

        cyc(1'b0, LDA, 1'b1, NONE, "reset_0");
        cyc(1'b0, JMP, 1'b1, NONE, "reset_1");
        cyc(1'b0, STO, 1'b0, NONE, "reset_2");
        cyc(1'b1, LDA, 1'b0, NONE, "release");

        // Fetch phases are driven with a different opcode to show they ignore it.
        instr(JMP, LDA, 1'b0, B_INC, B_RD, B_RD, B_RD | B_LDAC, "lda");
        instr(HLT, STO, 1'b1, B_INC, NONE, B_DE, B_WR | B_DE,   "sto");
        instr(SKZ, SKZ, 1'b1, B_INC, NONE, B_INC, NONE,          "skz_z1");
        instr(SKZ, SKZ, 1'b0, B_INC, NONE, NONE, NONE,           "skz_z0");
        instr(LDA, JMP, 1'b0, B_INC, NONE, B_LDPC, B_INC | B_LDPC, "jmp");
        instr(XOR, XOR, 1'b1, B_INC, B_RD, B_RD, B_RD | B_LDAC, "xor");
        instr(STO, AND, 1'b0, B_INC, B_RD, B_RD, B_RD | B_LDAC, "and");

        // Reset in ph5 of ADD: outputs drop next cycle, fetch restarts after release.
        fetch(ADD, "add_rst");
        cyc(1'b1, ADD, 1'b0, B_INC, "add_rst_ph4");
        cyc(1'b0, ADD, 1'b0, B_RD,  "add_rst_ph5");
        cyc(1'b1, ADD, 1'b0, NONE,  "add_rst_idle");
        instr(ADD, ADD, 1'b0, B_INC, B_RD, B_RD, B_RD | B_LDAC, "add");

`ifdef CTRL_SINGLE_STEP_EN
        step_mode = 1'b1;
        instr(LDA, LDA, 1'b0, B_INC, B_RD, B_RD, B_RD | B_LDAC, "step_lda");
        for (int i = 0; i < 3; i++) cyc(1'b1, STO, 1'b0, NONE, "step_wait");
        @(posedge clk);
        #1;
        step = 1'b1; step_mode = 1'b0;
        rst = 1'b1; opcode = JMP; zero = 1'b0;
        exp_q.push_back(NONE);
        name_q.push_back("step_pulse");
        @(posedge clk);
        #1;
        step = 1'b0;
        exp_q.push_back(B_SEL);
        name_q.push_back("step_resume_ph0");
        cyc(1'b1, JMP, 1'b0, B_SEL | B_RD,        "step_resume_ph1");
        cyc(1'b1, JMP, 1'b0, B_SEL | B_RD | B_IR, "step_resume_ph2");
        cyc(1'b1, JMP, 1'b0, B_SEL | B_RD | B_IR, "step_resume_ph3");
        cyc(1'b1, JMP, 1'b0, B_INC,               "step_resume_ph4");
        cyc(1'b1, JMP, 1'b0, NONE,                "step_resume_ph5");
        cyc(1'b1, JMP, 1'b0, B_LDPC,              "step_resume_ph6");
        cyc(1'b1, JMP, 1'b0, B_INC | B_LDPC,      "step_resume_ph7");
`endif

        // HLT: halt with inc_pc in ph4, then halt alone until reset.
        fetch(HLT, "hlt");
        cyc(1'b1, HLT, 1'b0, B_INC | B_HALT, "hlt_ph4");
        for (int i = 0; i < 20; i++) begin
            logic [2:0] v;
            v = 3'(i);
            cyc(1'b1, v, v[0], B_HALT, "halted");
        end
        cyc(1'b0, LDA, 1'b0, B_HALT, "halted_rst_edge");
        cyc(1'b1, LDA, 1'b0, NONE,   "halt_cleared");
        instr(LDA, LDA, 1'b0, B_INC, B_RD, B_RD, B_RD | B_LDAC, "post_halt_lda");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
